// File: rtl/ascii_seg_refresh_mux_if.sv
// ascii_seg_refresh_mux_if
//   Bundles the character-window input and the multiplexed display outputs of
//   ascii_seg_refresh_mux.
//   packed_ascii : four ASCII characters, [31:24] leftmost (an[3]), [7:0] rightmost (an[0])
//   seg          : active-low segments, seg[0]=a .. seg[6]=g
//   an           : active-low anode enables, one-hot-low when a digit is lit
//   digit_done   : one-cycle dwell pulse towards the upstream scroller
//   Modports: master drives packed_ascii; slave is the display multiplexer.
interface ascii_seg_refresh_mux_if;
  logic [31:0] packed_ascii;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        digit_done;

  modport master (
    output packed_ascii,
    input  seg,
    input  an,
    input  digit_done
  );

  modport slave (
    input  packed_ascii,
    output seg,
    output an,
    output digit_done
  );
endinterface

// File: rtl/ascii_seg_refresh_mux.sv
// ascii_seg_refresh_mux
//   Decodes a latched 4-character ASCII window to 7-segment glyphs and scans it
//   onto a 4-digit display, leftmost digit first, with a blank lead-in at the
//   start of every digit slot to suppress ghosting. Independently produces a
//   periodic one-cycle dwell pulse for the upstream scroller.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : slave side of ascii_seg_refresh_mux_if (packed_ascii in;
//           seg, an, digit_done out, all registered)
module ascii_seg_refresh_mux #(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned RW           = 17,
  parameter int unsigned DW           = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  ascii_seg_refresh_mux_if.slave bus
);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   frame_q, frame_d;
  logic          first_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          done_q, done_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          wrap;
  logic          dwell_end;
  logic [7:0]    cur_char;

  // Active-low glyph, bit 6 = segment a .. bit 0 = segment g.
  function automatic logic [6:0] decode(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;  // fold lower case onto upper
    case (u)
      8'h30:   decode = 7'b0000001;  // 0
      8'h31:   decode = 7'b1001111;  // 1
      8'h32:   decode = 7'b0010010;  // 2
      8'h33:   decode = 7'b0000110;  // 3
      8'h34:   decode = 7'b1001100;  // 4
      8'h35:   decode = 7'b0100100;  // 5
      8'h36:   decode = 7'b0100000;  // 6
      8'h37:   decode = 7'b0001111;  // 7
      8'h38:   decode = 7'b0000000;  // 8
      8'h39:   decode = 7'b0000100;  // 9
      8'h41:   decode = 7'b0001000;  // A
      8'h42:   decode = 7'b1100000;  // b
      8'h43:   decode = 7'b0110001;  // C
      8'h44:   decode = 7'b1000010;  // d
      8'h45:   decode = 7'b0110000;  // E
      8'h46:   decode = 7'b0111000;  // F
      8'h47:   decode = 7'b0100001;  // G
      8'h48:   decode = 7'b1001000;  // H
      8'h49:   decode = 7'b1001111;  // I
      8'h4A:   decode = 7'b1000011;  // J
      8'h4C:   decode = 7'b1110001;  // L
      8'h4E:   decode = 7'b1101010;  // n
      8'h4F:   decode = 7'b1100010;  // o
      8'h50:   decode = 7'b0011000;  // P
      8'h51:   decode = 7'b0001100;  // q
      8'h52:   decode = 7'b1111010;  // r
      8'h53:   decode = 7'b0100100;  // S
      8'h54:   decode = 7'b1110000;  // t
      8'h55:   decode = 7'b1000001;  // U
      8'h59:   decode = 7'b1000100;  // y
      8'h2D:   decode = 7'b1111110;  // -
      default: decode = 7'b1111111;  // blank
    endcase
  endfunction

  always_comb begin
    wrap      = (rcnt_q == RW'(REFRESH_DIV - 1));
    rcnt_d    = wrap ? '0 : rcnt_q + RW'(1);
    idx_d     = wrap ? idx_q - 2'd1 : idx_q;
    // New word only at a frame boundary (index 0 -> 3), so a scan never tears.
    frame_d   = (first_q || (wrap && idx_q == 2'd0)) ? bus.packed_ascii : frame_q;

    dwell_end = (dcnt_q == DW'(DWELL_CYCLES - 1));
    dcnt_d    = dwell_end ? '0 : dcnt_q + DW'(1);
    done_d    = dwell_end;

    cur_char  = frame_q[{idx_q, 3'b000} +: 8];
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    if (rcnt_q >= RW'(BLANK_CYCLES)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(cur_char);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q  <= '0;
      idx_q   <= 2'd3;
      frame_q <= 32'h2020_2020;
      first_q <= 1'b1;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      first_q <= 1'b0;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.digit_done = done_q;

endmodule

// File: doc/ascii_seg_refresh_mux.md
Name: ascii_seg_refresh_mux

Overview:
- Downstream stage of the scrolling ASCII display.
- Takes a 4-character packed ASCII window, decodes each character to 7-segment patterns, and time-multiplexes them onto the 4-digit display with a per-digit refresh timer and anti-ghost blanking.
- Also generates the one-cycle dwell pulse that tells the upstream scroller when to advance.

Parameters:
- REFRESH_DIV, 100_000: clk cycles each digit is selected (1 kHz digit rate at 100 MHz).
- BLANK_CYCLES, 1_000: cycles at the start of each digit slot with all anodes off. Must be less than REFRESH_DIV.
- DWELL_CYCLES, 50_000_000: clk cycles between digit_done pulses (0.5 s at 100 MHz).
- RW, 17: width of the refresh counter. Must satisfy 2^RW > REFRESH_DIV.
- DW, 26: width of the dwell counter. Must satisfy 2^DW > DWELL_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- packed_ascii, input, 32: four ASCII characters. Bits [31:24] are the leftmost character (an[3]); bits [7:0] are the rightmost (an[0]).
- seg, output, [0:6]: active-low segments. seg[0]=a through seg[6]=g.
- an, output, 4: active-low anode enables, one-hot-low when active.
- digit_done, output, 1: one-cycle high pulse every DWELL_CYCLES cycles.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous and active-low (reset).
  - While reset=0: seg=7'b1111111, an=4'b1111, digit_done=0, all counters 0, digit index=3, frame latch=32'h20202020 (four spaces).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On each wrap, the digit index decrements 3→2→1→0→3.
- Frame latch:
  - Loads packed_ascii in the cycle the index moves from 0 to 3.
  - Also loads on the first clock after reset release.
  - Input changes never tear a frame: all four digits of one scan show the same latched word.
- Blanking:
  - While refresh counter < BLANK_CYCLES: an=4'b1111 and seg=7'b1111111.
  - Otherwise: an[idx]=0, other anode bits 1, seg=decode(latch[8*idx+7 -: 8]).
- Output timing: seg and an are registered, so the visible output lags the counter state by 1 cycle.
- Decode (active-low pattern, order abcdefg):
  - '0'..'9': standard glyphs. '0'=0000001, '1'=1001111, '8'=0000000.
  - Letters A b C d E F G H I J L n o P q r S t U y, case-insensitive (upper and lower map to the same glyph).
    - 'H'=1001000, 'E'=0110000, 'L'=1110001, 'o'=1100010, 'J'=1000011, 'F'=0111000.
  - '-' = 1111110.
  - Space, 8'h00, and every other code: 1111111 (blank).
- Dwell counter:
  - Free-running, counts 0..DWELL_CYCLES-1.
  - digit_done is registered high for exactly the cycle after the counter reaches DWELL_CYCLES-1. The counter wraps to 0 on that same edge.
  - The dwell counter is independent of the refresh counter.
- Reset mid-operation: all state returns to reset values immediately (asynchronously). Scanning restarts at index 3 with a blank slot.
- Edge cases:
  - REFRESH_DIV=1 is allowed only with BLANK_CYCLES=0.
  - DWELL_CYCLES=1 makes digit_done continuously high after the first cycle.

Test Plan (bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, DWELL_CYCLES=20):
- Reset: hold reset=0 for 5 cycles with packed_ascii=32'h31313131 -> an=1111, seg=1111111, digit_done=0 throughout. Release reset -> first an=0111 appears 3 cycles later (2 blank cycles + 1 register stage).
- Scan order and decode: packed_ascii="HELo" (32'h48454C6F) -> over one 32-cycle frame, an sequence 0111/1011/1101/1110 with seg 1001000/0110000/1110001/1100010. Each digit is active 6 cycles, preceded by 2 blank cycles.
- Case and unsupported codes: "hElJ" shows the same glyph for 'h' as for 'H'. 8'h00, 8'h20, '@' and '~' each give seg=1111111 in their slot.
- No tearing: change packed_ascii from "1111" to "8888" while idx=2 -> digits 2..0 still show '1' for the rest of that frame. All four digits show '8' from the next frame on.
- Dwell pulse: digit_done is high exactly on cycles 20, 40, 60 after reset release, each pulse 1 cycle wide, and its timing is unaffected by packed_ascii changes.
- Reset mid-frame: assert reset=0 at idx=1, cycle 4 of the slot -> outputs go blank within the same cycle without a clock edge. After release, the scan restarts at an=0111 and the dwell count restarts from 0.
